shiftreg_ctrl: RTL



---
 rtl/shiftreg_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shiftreg_ctrl.sv
// rtl/shiftreg_ctrl.sv - valid/enable sequencer for the widening shift-register datapath
module shiftreg_ctrl #(
    parameter  int NumStages = 5,
    localparam int CntWidth  = $clog2(NumStages + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NumStages-1:0] stage_en_o,
    input  logic                 flush_i,
    input  logic                 clear_i,
    output logic                 flush_done_o,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  count_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [NumStages-1:0] v_q;
    logic [NumStages-1:0] v_d;
    logic [NumStages-1:0] free;
    logic [NumStages-1:0] src;
    logic [NumStages-1:0] stage_en;
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [CntWidth-1:0]  count_q;
    logic [CntWidth-1:0]  count_d;
    logic                 accept;
    logic                 in_xfer;

    // A register can load when it is empty or its contents move on this cycle;
    // walked from the output end so that bubbles anywhere downstream collapse.
    always_comb begin
        logic chain;
        free  = '0;
        chain = out_ready_i;
        for (int i = NumStages - 1; i >= 0; i--) begin
            chain   = !v_q[i] | chain;
            free[i] = chain;
        end
    end

    // New samples are refused while draining, flushing, clearing or in reset.
    assign accept     = (state_q != StDrain) & !flush_i & !clear_i & !rst_i;
    assign src        = {v_q[NumStages-2:0], in_valid_i & accept};
    assign stage_en   = clear_i ? '0 : (src & free);
    assign in_ready_o = free[0] & accept;
    assign in_xfer    = in_valid_i & in_ready_o;

    // Next-valid: a register is valid if it loads now or holds because its successor is blocked.
    always_comb begin
        v_d = '0;
        for (int i = 0; i < NumStages - 1; i++) begin
            v_d[i] = stage_en[i] | (v_q[i] & !free[i+1]);
        end
        v_d[NumStages-1] = stage_en[NumStages-1] | (v_q[NumStages-1] & !out_ready_i);
        if (clear_i) begin
            v_d = '0;
        end
    end

    // Occupancy is the popcount of the next valid vector so it tracks v exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NumStages; i++) begin
            count_d = count_d + CntWidth'(v_d[i]);
        end
    end

    // Sequencing state: idle, moving samples, or draining without new input.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        state_d = StDrain;
                    end else if (in_xfer) begin
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (flush_i) begin
                        state_d = StDrain;
                    end else if (count_d == '0) begin
                        state_d = StIdle;
                    end
                end
                StDrain: begin
                    if (count_q == '0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; reset empties the pipeline the same way clear does.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q     <= '0;
            count_q <= '0;
            state_q <= StIdle;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign stage_en_o   = stage_en;
    assign out_valid_o  = v_q[NumStages-1];
    assign count_o      = count_q;
    assign busy_o       = (state_q != StIdle);
    assign flush_done_o = (state_q == StDrain) && (count_q == '0);

    a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CntWidth'(NumStages));
    a_en_needs_free : assert property (@(posedge clk_i) disable iff (rst_i)
        (stage_en & ~free) == '0);
    a_no_load_in_drain : assert property (@(posedge clk_i) disable iff (rst_i)
        !((state_q == StDrain) && stage_en[0]));

endmodule
